// File: rtl/wb_led_responder_pkg.sv
// bus_defs: shared Wishbone widths, register offsets and CTRL bit positions
package bus_defs;

    localparam int WB_AW = 32;
    localparam int WB_DW = 32;
    localparam int WB_SW = WB_DW / 8;

    localparam logic [7:0] OFF_LED    = 8'h00;
    localparam logic [7:0] OFF_STATUS = 8'h04;
    localparam logic [7:0] OFF_DIV    = 8'h08;
    localparam logic [7:0] OFF_CTRL   = 8'h0C;
    localparam logic [7:0] OFF_ID     = 8'h10;

    localparam int CTRL_BLINK_EN = 0;
    localparam int CTRL_LED_TEST = 1;

    // Replace only the byte lanes whose select bit is set.
    function automatic logic [WB_DW-1:0] byte_merge(
        input logic [WB_DW-1:0] old_v,
        input logic [WB_DW-1:0] new_v,
        input logic [WB_SW-1:0] sel
    );
        logic [WB_DW-1:0] r;
        r = old_v;
        for (int i = 0; i < WB_SW; i++)
            r[8*i +: 8] = sel[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
        return r;
    endfunction

endpackage

// File: rtl/wb_led_responder_blink_timer.sv
// blink_timer: half-period counter that toggles the heartbeat output
module blink_timer
    import bus_defs::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en,
    input  logic [WB_DW-1:0] div,
    input  logic             clr,
    output logic             blinker
);

    logic [WB_DW-1:0] r_cnt;
    logic             r_blink;

    // Disabled or zero divider parks everything; a clear restarts the half-period
    // but keeps the level; >= guards against any count beyond a shrunken divider.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_cnt   <= '0;
            r_blink <= 1'b0;
        end else if (!en || div == '0) begin
            r_cnt   <= '0;
            r_blink <= 1'b0;
        end else if (clr) begin
            r_cnt   <= '0;
        end else if (r_cnt >= div - 32'd1) begin
            r_cnt   <= '0;
            r_blink <= ~r_blink;
        end else begin
            r_cnt   <= r_cnt + 32'd1;
        end
    end

    assign blinker = r_blink;

endmodule

// File: rtl/wb_led_responder.sv
// wb_led_responder: Wishbone classic slave owning the LED bank, status LEDs and blinker
module wb_led_responder
    import bus_defs::*;
#(
    parameter logic [WB_AW-1:0] BASE_ADDR   = 32'h0000_3000,
    parameter logic [WB_DW-1:0] DEFAULT_DIV = 32'd25_000_000,
    parameter logic [WB_DW-1:0] ID_VALUE    = 32'h4C45_4401
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WB_AW-1:0] addr_i,
    input  logic [WB_DW-1:0] dat_i,
    output logic [WB_DW-1:0] dat_o,
    input  logic             we_i,
    input  logic [WB_SW-1:0] sel_i,
    input  logic             cyc_i,
    input  logic             stb_i,
    output logic             ack_o,
    output logic             err_o,
    output logic             rty_o,
    output logic [9:0]       led_port,
    output logic [5:0]       status_led,
    output logic             blinker
);

    logic [9:0]       r_led;
    logic [5:0]       r_status;
    logic [WB_DW-1:0] r_div;
    logic [1:0]       r_ctrl;
    logic             r_ack;
    logic             r_err;
    logic [WB_DW-1:0] r_dat;

    logic [7:0]       w_off;
    logic             w_sel;
    logic             w_start;
    logic             w_legal;
    logic             w_wr;
    logic             w_clr;
    logic [WB_DW-1:0] w_rdata;
    logic [WB_DW-1:0] w_wdata;

    assign w_off   = addr_i[7:0];
    assign w_sel   = cyc_i & stb_i & (addr_i[WB_AW-1:8] == BASE_ADDR[WB_AW-1:8]);
    assign w_start = w_sel & ~r_ack & ~r_err;
    assign w_wr    = w_start & w_legal & we_i;
    assign w_clr   = w_wr & ((w_off == OFF_DIV) | (w_off == OFF_CTRL));

    // Address decode: legal offsets, read mux and lane-merged write value.
    // Misaligned offsets never match the table, so they fall into err.
    always_comb begin
        w_legal = (w_off == OFF_LED) | (w_off == OFF_STATUS) | (w_off == OFF_DIV) |
                  (w_off == OFF_CTRL) | ((w_off == OFF_ID) & ~we_i);
        w_rdata = (w_off == OFF_LED)    ? {22'd0, r_led}    :
                  (w_off == OFF_STATUS) ? {26'd0, r_status} :
                  (w_off == OFF_DIV)    ? r_div             :
                  (w_off == OFF_CTRL)   ? {30'd0, r_ctrl}   :
                  (w_off == OFF_ID)     ? ID_VALUE          : '0;
        w_wdata = byte_merge(w_rdata, dat_i, sel_i);
    end

    // One-cycle termination; dat_o is nonzero only on a read ack so the
    // top-level OR mux with other slaves stays clean.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_ack <= 1'b0;
            r_err <= 1'b0;
            r_dat <= '0;
        end else begin
            r_ack <= w_start & w_legal;
            r_err <= w_start & ~w_legal;
            r_dat <= (w_start & w_legal & ~we_i) ? w_rdata : '0;
        end
    end

    // Register writes commit on the same edge that raises ack_o.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_led    <= '0;
            r_status <= '0;
            r_div    <= DEFAULT_DIV;
            r_ctrl   <= 2'b01;
        end else if (w_wr) begin
            if (w_off == OFF_LED)    r_led    <= w_wdata[9:0];
            if (w_off == OFF_STATUS) r_status <= w_wdata[5:0];
            if (w_off == OFF_DIV)    r_div    <= w_wdata;
            if (w_off == OFF_CTRL)   r_ctrl   <= w_wdata[1:0];
        end
    end

    blink_timer u_blink (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .en      (r_ctrl[CTRL_BLINK_EN]),
        .div     (r_div),
        .clr     (w_clr),
        .blinker (blinker)
    );

    assign led_port   = r_ctrl[CTRL_LED_TEST] ? 10'h3FF : r_led;
    assign status_led = r_status;
    assign ack_o      = r_ack;
    assign err_o      = r_err;
    assign dat_o      = r_dat;
    assign rty_o      = 1'b0;

endmodule

// File: doc/wb_led_responder.md
Name: wb_led_responder

Overview:
- Wishbone classic slave on the shared control bus; its data, err and rty outputs are OR-combined with the other slaves' outputs at top level.
- Receives bus cycles from the control unit and provides registers for the board indicators: a 10-bit LED bank, 6 status LEDs and a programmable blinker.
- Moves indicator ownership from direct control-unit wiring to a bus-addressed peripheral.

Parameters:
- BASE_ADDR, 32'h0000_3000, base of this slave's 256-byte window; compare addr_i[31:8].
- DEFAULT_DIV, 32'd25_000_000, reset value of BLINK_DIV (half-period in clk_i cycles).
- ID_VALUE, 32'h4C45_4401, constant returned by the ID register.

Ports:
- clk_i  in  1  system clock; single clock domain.
- rst_i  in  1  asynchronous, active-low reset.
- addr_i  in  32  byte address.
- dat_i  in  32  write data.
- dat_o  out  32  read data; all zeros whenever ack_o is low.
- we_i  in  1  write enable.
- sel_i  in  4  byte lanes; sel_i[n] qualifies dat_i[8n+7:8n].
- cyc_i  in  1  bus cycle.
- stb_i  in  1  strobe.
- ack_o  out  1  normal termination.
- err_o  out  1  error termination.
- rty_o  out  1  retry; tied 0.
- led_port  out  10  LED bank.
- status_led  out  6  status LEDs.
- blinker  out  1  heartbeat output.

Behaviour:
- Selection: sel = cyc_i & stb_i & (addr_i[31:8] == BASE_ADDR[31:8]).
- Termination, registered: on a rising edge with sel=1 and ack_o=0 and err_o=0, exactly one of ack_o or err_o goes high for one cycle.
  - Termination is forced low the following cycle even if stb_i is still high.
  - A held strobe therefore gets one termination every 2 cycles.
  - Read/write side effects occur on the same edge that asserts ack_o.
- Register map, offset = addr_i[7:0]:
  - 0x00 LED_OUT, RW, bits [9:0]; upper bits read 0.
  - 0x04 STATUS, RW, bits [5:0].
  - 0x08 BLINK_DIV, RW, 32 bits.
  - 0x0C CTRL, RW: bit0 blink_en, bit1 led_test.
  - 0x10 ID, RO, returns ID_VALUE.
- Error cases: err_o instead of ack_o, no state change, for
  - any other offset;
  - offset[1:0] != 0;
  - a write to ID.
- Byte-lane writes: only lanes with sel_i set are updated. sel_i=0 on a write still acks and changes nothing.
- Read data: dat_o holds the register value during the ack cycle and is 0 otherwise, including on err cycles. This is required for the top-level OR mux.
- Reset (rst_i=0, async):
  - LED_OUT=0, STATUS=0, BLINK_DIV=DEFAULT_DIV, CTRL=0x1.
  - ack_o=0, err_o=0, dat_o=0, blinker=0, blink counter=0.
  - Reset asserted mid-cycle drops the termination immediately. The master must re-issue the access.
- Outputs:
  - led_port = led_test ? 10'h3FF : LED_OUT.
  - status_led = STATUS.
  - Both update the cycle after the write ack edge.
- Blinker, 32-bit counter cnt:
  - If blink_en=0 or BLINK_DIV=0: cnt=0 and blinker=0.
  - Otherwise, if cnt == BLINK_DIV-1: cnt<=0 and blinker toggles; else cnt<=cnt+1.
  - BLINK_DIV=1 toggles every cycle.
  - Any acked write to BLINK_DIV or CTRL clears cnt to 0 on the same edge; blinker level is kept.
  - Writing BLINK_DIV below the current cnt takes effect through that same clear, so there is no wrap-around to 2^32.

Decomposition:
- Shared package (bus_defs): register offsets (OFF_LED, OFF_STATUS, OFF_DIV, OFF_CTRL, OFF_ID), CTRL bit indices, WB data/address width constants.
- One sub-module, blink_timer (clk_i, rst_i, en, div, clr -> blinker), holding the counter and toggle logic.
- The top holds bus decode, registers and termination.

Test Plan:
- Reset release, then read 0x10 -> ack_o 1 cycle after strobe, dat_o=32'h4C454401; dat_o=0 the next cycle.
- Write 0x00 dat 32'h0000_02A5 sel 4'hF -> ack; led_port=10'h2A5. Write again with sel 4'h2, dat 32'h0000_0100 -> led_port=10'h1A5.
- Write CTRL=0x3 -> led_port=10'h3FF while LED_OUT reads back 10'h1A5. Write CTRL=0x1 -> led_port returns to 10'h1A5.
- Write BLINK_DIV=4 with blink_en=1 -> blinker toggles every 4 clk_i cycles, period 8. Write BLINK_DIV=0 -> blinker=0 and stays 0.
- Read offsets 0x14 and 0x02, and write 0x10 -> err_o pulse with ack_o=0, dat_o=0, ID unchanged. An address outside BASE_ADDR gives no response at all.
- stb_i held 6 cycles on a read -> ack pattern 0,1,0,1,0,1. Reset asserted during the ack cycle -> ack_o drops asynchronously and all registers return to reset values.
